// File: rtl/temp_window_monitor.sv
// -----------------------------------------------------------------------------
// temp_window_monitor
//
// Purpose:
//   Sink end of the sensor channel stream. Consumes {channel, data} records,
//   maps stream channel codes onto monitored temperature indices, checks each
//   sample against the inclusive window [P_MIN_TEMP_HW, P_MAX_TEMP_HW] with a
//   per-channel debounce, and drives a latched temperature fault to the
//   safety subsystem's fault aggregator.
//
//   The channel map literal lists four codes, so four temperature channels
//   are monitored by default (temp index i <-> stream code P_TEMP_CH_MAP[i]).
//
// Optional feature (macro SAFETY_TEMP_STALE_CHECK_EN):
//   Defined   : one 32-bit cycle counter per temperature channel; a channel
//               not sampled for P_TIMEOUT_CYCLES cycles sets fault_stale[i].
//   Undefined : no counters, fault_stale stays 0.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   s_valid/s_ready record handshake (see below)
//   s_channel[3:0]  stream channel code
//   s_data[31:0]    signed two's complement degC for temperature channels
//   clear_fault     single-cycle request to leave FAULT
//   temp_ok         1 only in RUN
//   fault_latched   1 in FAULT
//   fault_over/under/stale[N-1:0]  sticky per-channel trip flags
//   chan_err        sticky: a record arrived with an illegal channel code
//
// Handshake: a record transfers on every rising clk edge where
//   s_valid & s_ready are both 1. s_ready is 0 in reset and 1 on every cycle
//   afterwards; there is no backpressure and s_ready never depends on s_valid.
//
// Latency: record accepted on the edge ending cycle N -> stage1 register;
//   edge ending N+1 -> counters, seen mask and trip pulses; edge ending N+2
//   -> sticky flags, FSM state, temp_ok / fault_latched.
// -----------------------------------------------------------------------------
module temp_window_monitor #(
   parameter int P_NO_CHANNELS                          = 9,
   parameter int P_NO_TEMP_CHANNELS                     = 4,
   parameter int P_TEMP_CH_MAP [P_NO_TEMP_CHANNELS-1:0] = '{4, 3, 2, 1},
   parameter int P_MAX_TEMP_HW                          = 60,
   parameter int P_MIN_TEMP_HW                          = 0,
   parameter int P_DEBOUNCE                             = 3,
   parameter int P_TIMEOUT_CYCLES                       = 1000000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [3:0]                    s_channel,
   input  logic [31:0]                   s_data,
   input  logic                          clear_fault,
   output logic                          temp_ok,
   output logic                          fault_latched,
   output logic [P_NO_TEMP_CHANNELS-1:0] fault_over,
   output logic [P_NO_TEMP_CHANNELS-1:0] fault_under,
   output logic [P_NO_TEMP_CHANNELS-1:0] fault_stale,
   output logic                          chan_err
);

   localparam int                 N    = P_NO_TEMP_CHANNELS;
   localparam int                 W_DB = $clog2(P_DEBOUNCE + 1);
   localparam logic signed [31:0] L_MAX = 32'(P_MAX_TEMP_HW);
   localparam logic signed [31:0] L_MIN = 32'(P_MIN_TEMP_HW);
   localparam logic [W_DB-1:0]    L_DB  = W_DB'(P_DEBOUNCE);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_ready;
   logic                  r_s1_valid;
   logic [3:0]            r_s1_ch;
   logic signed [31:0]    r_s1_data;
   logic [W_DB-1:0]       r_db_cnt [N];
   logic [N-1:0]          r_seen;
   logic [N-1:0]          r_over_hit;
   logic [N-1:0]          r_under_hit;
   logic                  r_chan_hit;

   logic [N-1:0]          w_sel;
   logic [N-1:0]          w_over;
   logic [N-1:0]          w_under;
   logic [N-1:0]          w_over_trip;
   logic [N-1:0]          w_under_trip;
   logic [W_DB-1:0]       w_db_next [N];
   logic [N-1:0]          w_stale_hit;
   logic                  w_illegal;
   logic                  w_any_hit;
   logic                  w_do_clear;

   assign s_ready = r_ready;

   // Stage 2 combinational: decode, signed window compare, debounce next value.
   always_comb begin
      w_illegal = r_s1_valid && ({28'd0, r_s1_ch} >= 32'(P_NO_CHANNELS));
      for (int i = 0; i < N; i++) begin
         w_sel[i]   = r_s1_valid && (r_s1_ch == 4'(P_TEMP_CH_MAP[i]));
         w_over[i]  = w_sel[i] && (r_s1_data > L_MAX);
         w_under[i] = w_sel[i] && (r_s1_data < L_MIN);
         if (w_over[i] || w_under[i])
            w_db_next[i] = (r_db_cnt[i] == L_DB) ? L_DB : r_db_cnt[i] + W_DB'(1);
         else if (w_sel[i])
            w_db_next[i] = '0;
         else
            w_db_next[i] = r_db_cnt[i];
         // Trip is attributed to the direction of the sample that reached the limit.
         w_over_trip[i]  = w_over[i]  && (w_db_next[i] == L_DB);
         w_under_trip[i] = w_under[i] && (w_db_next[i] == L_DB);
      end
   end

   assign w_any_hit  = (|r_over_hit) || (|r_under_hit) || r_chan_hit || (|w_stale_hit);
   // A trip arriving together with clear_fault keeps the block in FAULT.
   assign w_do_clear = (r_state == ST_FAULT) && clear_fault && !w_any_hit;

   // Stage 1: register the accepted record.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ready    <= 1'b0;
         r_s1_valid <= 1'b0;
         r_s1_ch    <= '0;
         r_s1_data  <= '0;
      end else begin
         r_ready    <= 1'b1;
         r_s1_valid <= s_valid && r_ready;
         r_s1_ch    <= s_channel;
         r_s1_data  <= s_data;
      end
   end

   // Stage 2: debounce counters, seen mask, single-cycle trip pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) r_db_cnt[i] <= '0;
         r_seen      <= '0;
         r_over_hit  <= '0;
         r_under_hit <= '0;
         r_chan_hit  <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (w_do_clear) begin
               r_db_cnt[i] <= '0;
               r_seen[i]   <= 1'b0;
            end else begin
               r_db_cnt[i] <= w_db_next[i];
               if (w_sel[i] && !w_over[i] && !w_under[i]) r_seen[i] <= 1'b1;
            end
         end
         r_over_hit  <= w_over_trip;
         r_under_hit <= w_under_trip;
         r_chan_hit  <= w_illegal;
      end
   end

`ifdef SAFETY_TEMP_STALE_CHECK_EN
   localparam logic [31:0] L_TO = 32'(P_TIMEOUT_CYCLES);
   logic [31:0] r_stale_cnt [N];

   // Counters run in INIT/RUN, restart on each sample, hold at the limit.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (reset || (r_state == ST_FAULT))
            r_stale_cnt[i] <= '0;
         else if (w_sel[i])
            r_stale_cnt[i] <= '0;
         else if (r_stale_cnt[i] != L_TO)
            r_stale_cnt[i] <= r_stale_cnt[i] + 32'd1;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) w_stale_hit[i] = (r_stale_cnt[i] == L_TO);
   end
`else
   assign w_stale_hit = '0;
`endif

   // FSM with registered outputs and sticky fault vectors.
   always_ff @(posedge clk) begin
      if (reset || w_do_clear) begin
         r_state       <= ST_INIT;
         temp_ok       <= 1'b0;
         fault_latched <= 1'b0;
         fault_over    <= '0;
         fault_under   <= '0;
         fault_stale   <= '0;
         chan_err      <= 1'b0;
      end else begin
         fault_over  <= fault_over  | r_over_hit;
         fault_under <= fault_under | r_under_hit;
         fault_stale <= fault_stale | w_stale_hit;
         chan_err    <= chan_err    | r_chan_hit;
         case (r_state)
            ST_INIT: begin
               if (w_any_hit) begin
                  r_state       <= ST_FAULT;
                  temp_ok       <= 1'b0;
                  fault_latched <= 1'b1;
               end else if (&r_seen) begin
                  r_state <= ST_RUN;
                  temp_ok <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_any_hit) begin
                  r_state       <= ST_FAULT;
                  temp_ok       <= 1'b0;
                  fault_latched <= 1'b1;
               end
            end
            ST_FAULT: begin
               temp_ok       <= 1'b0;
               fault_latched <= 1'b1;
            end
            default: begin
               r_state       <= ST_FAULT;
               temp_ok       <= 1'b0;
               fault_latched <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_temp_window_monitor.sv
// -----------------------------------------------------------------------------
// tb_temp_window_monitor
//
// Directed bench for temp_window_monitor. Temperature index i lives on stream
// code i+1 (default channel map). Inputs are driven and outputs sampled on the
// falling clock edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_temp_window_monitor;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [3:0]    s_channel = '0;
   logic [31:0]   s_data = '0;
   logic          clear_fault = 1'b0;
   logic          temp_ok;
   logic          fault_latched;
   logic [N-1:0]  fault_over;
   logic [N-1:0]  fault_under;
   logic [N-1:0]  fault_stale;
   logic          chan_err;

   int tests_run = 0;
   int fails     = 0;

   temp_window_monitor #(
      .P_TIMEOUT_CYCLES(100)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_channel    (s_channel),
      .s_data       (s_data),
      .clear_fault  (clear_fault),
      .temp_ok      (temp_ok),
      .fault_latched(fault_latched),
      .fault_over   (fault_over),
      .fault_under  (fault_under),
      .fault_stale  (fault_stale),
      .chan_err     (chan_err)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset       = 1'b1;
      s_valid     = 1'b0;
      clear_fault = 1'b0;
      idle(2);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // One record; returns on the falling edge right after the accepting edge.
   task automatic send(input logic [3:0] ch, input logic [31:0] data);
      s_valid   = 1'b1;
      s_channel = ch;
      s_data    = data;
      @(negedge clk);
      s_valid   = 1'b0;
   endtask

   task automatic send_all_ok();
      for (int c = 1; c <= N; c++) send(4'(c), 32'd25);
   endtask

   task automatic bring_up();
      do_reset();
      send_all_ok();
      idle(3);
   endtask

   task automatic pulse_clear();
      clear_fault = 1'b1;
      @(negedge clk);
      clear_fault = 1'b0;
   endtask

   // Scenarios
   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      tests_run++;
      if ({s_ready, temp_ok, fault_latched, chan_err} !== 4'b0000) begin
         $display("FAIL reset_ctrl: got %b exp 0000", {s_ready, temp_ok, fault_latched, chan_err});
         fails++;
      end
      tests_run++;
      if ({fault_over, fault_under, fault_stale} !== '0) begin
         $display("FAIL reset_vec: got %h exp 0", {fault_over, fault_under, fault_stale});
         fails++;
      end
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (s_ready !== 1'b1) begin
         $display("FAIL ready_after_reset: got %b exp 1", s_ready);
         fails++;
      end
   endtask

   task automatic test_run_entry();
      do_reset();
      for (int c = 1; c < N; c++) send(4'(c), 32'd25);
      send(4'(N), 32'd25);
      idle(1);
      tests_run++;
      if (temp_ok !== 1'b0) begin
         $display("FAIL run_latency_early: got %b exp 0", temp_ok);
         fails++;
      end
      idle(1);
      tests_run++;
      if (temp_ok !== 1'b1) begin
         $display("FAIL run_entry: got %b exp 1", temp_ok);
         fails++;
      end
      tests_run++;
      if ({fault_latched, chan_err, fault_over, fault_under, fault_stale} !== '0) begin
         $display("FAIL run_no_faults: got %h exp 0",
                  {fault_latched, chan_err, fault_over, fault_under, fault_stale});
         fails++;
      end
   endtask

   task automatic test_over();
      bring_up();
      send(4'd3, 32'd61);
      send(4'd3, 32'd61);
      send(4'd3, 32'd61);
      idle(1);
      tests_run++;
      if (fault_over !== 4'b0000) begin
         $display("FAIL over_latency_early: got %b exp 0000", fault_over);
         fails++;
      end
      idle(1);
      tests_run++;
      if ({fault_over, fault_latched, temp_ok} !== 6'b0100_1_0) begin
         $display("FAIL over_trip: got %b exp 010010", {fault_over, fault_latched, temp_ok});
         fails++;
      end
      // Interrupted run does not trip.
      bring_up();
      send(4'd3, 32'd61);
      send(4'd3, 32'd25);
      send(4'd3, 32'd61);
      idle(3);
      tests_run++;
      if ({fault_over, fault_latched, temp_ok} !== 6'b0000_0_1) begin
         $display("FAIL over_interrupted: got %b exp 000001", {fault_over, fault_latched, temp_ok});
         fails++;
      end
   endtask

   task automatic test_under();
      bring_up();
      for (int k = 0; k < 3; k++) send(4'd2, 32'hFFFF_FFFF);
      idle(3);
      tests_run++;
      if ({fault_under, fault_over, fault_latched} !== 9'b0010_0000_1) begin
         $display("FAIL under_trip: got %b exp 001000001", {fault_under, fault_over, fault_latched});
         fails++;
      end
      // Limits are in-window; a limit sample breaks an out-of-window run.
      bring_up();
      for (int k = 0; k < 4; k++) send(4'd1, 32'd60);
      for (int k = 0; k < 4; k++) send(4'd4, 32'd0);
      send(4'd2, 32'd61);
      send(4'd2, 32'd61);
      send(4'd2, 32'd60);
      send(4'd2, 32'd61);
      send(4'd2, 32'd61);
      idle(3);
      tests_run++;
      if ({fault_over, fault_under, fault_latched, temp_ok} !== 10'b0000_0000_0_1) begin
         $display("FAIL boundary_no_trip: got %b exp 0000000001",
                  {fault_over, fault_under, fault_latched, temp_ok});
         fails++;
      end
   endtask

   task automatic test_chan_err();
      bring_up();
      send(4'd9, 32'h1234_5678);
      idle(3);
      tests_run++;
      if ({chan_err, fault_latched, temp_ok, fault_over, fault_under} !== 11'b1_1_0_0000_0000) begin
         $display("FAIL chan_err: got %b exp 11000000000",
                  {chan_err, fault_latched, temp_ok, fault_over, fault_under});
         fails++;
      end
      pulse_clear();
      tests_run++;
      if ({chan_err, fault_latched, temp_ok} !== 3'b000) begin
         $display("FAIL clear_to_init: got %b exp 000", {chan_err, fault_latched, temp_ok});
         fails++;
      end
      // The seen mask was cleared: one channel alone is not enough.
      send(4'd1, 32'd25);
      idle(3);
      tests_run++;
      if (temp_ok !== 1'b0) begin
         $display("FAIL seen_cleared: got %b exp 0", temp_ok);
         fails++;
      end
      send_all_ok();
      idle(3);
      tests_run++;
      if (temp_ok !== 1'b1) begin
         $display("FAIL rerun_after_clear: got %b exp 1", temp_ok);
         fails++;
      end
      pulse_clear();
      idle(1);
      tests_run++;
      if ({temp_ok, fault_latched} !== 2'b10) begin
         $display("FAIL clear_in_run: got %b exp 10", {temp_ok, fault_latched});
         fails++;
      end
   endtask

   task automatic test_clear_vs_trip();
      bring_up();
      for (int k = 0; k < 3; k++) send(4'd1, 32'd70);
      idle(3);
      // Second trip's pulse coincides with clear_fault.
      for (int k = 0; k < 3; k++) send(4'd2, 32'd70);
      idle(1);
      clear_fault = 1'b1;
      @(negedge clk);
      clear_fault = 1'b0;
      tests_run++;
      if ({fault_latched, fault_over} !== 5'b1_0011) begin
         $display("FAIL clear_vs_trip: got %b exp 10011", {fault_latched, fault_over});
         fails++;
      end
      idle(1);
      pulse_clear();
      tests_run++;
      if ({fault_latched, fault_over} !== 5'b0_0000) begin
         $display("FAIL clear_after_trip: got %b exp 00000", {fault_latched, fault_over});
         fails++;
      end
   endtask

   task automatic test_stale();
      do_reset();
      for (int loop = 0; loop < 22; loop++) begin
         send(4'd1, 32'd25);
         send(4'd2, 32'd25);
         send(4'd3, 32'd25);
         idle(3);
         if (loop == 12) begin
            tests_run++;
            if (fault_stale !== 4'b0000) begin
               $display("FAIL stale_early: got %b exp 0000", fault_stale);
               fails++;
            end
         end
      end
`ifdef SAFETY_TEMP_STALE_CHECK_EN
      tests_run++;
      if ({fault_stale, fault_latched} !== 5'b1000_1) begin
         $display("FAIL stale_trip: got %b exp 10001", {fault_stale, fault_latched});
         fails++;
      end
`else
      tests_run++;
      if ({fault_stale, fault_latched, temp_ok} !== 6'b0000_0_0) begin
         $display("FAIL stale_disabled: got %b exp 000000", {fault_stale, fault_latched, temp_ok});
         fails++;
      end
`endif
   endtask

   task automatic test_reset_midstream();
      bring_up();
      send(4'd2, 32'hFFFF_FFFF);
      send(4'd2, 32'hFFFF_FFFF);
      idle(3);
      // Third under-sample and an illegal code in flight when reset hits.
      send(4'd2, 32'hFFFF_FFFF);
      send(4'd9, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({s_ready, temp_ok, fault_latched, chan_err, fault_over, fault_under, fault_stale} !== '0) begin
         $display("FAIL midstream_reset: got %h exp 0",
                  {s_ready, temp_ok, fault_latched, chan_err, fault_over, fault_under, fault_stale});
         fails++;
      end
      reset = 1'b0;
      idle(4);
      tests_run++;
      if ({fault_latched, chan_err, fault_under} !== 6'b0) begin
         $display("FAIL midstream_dropped: got %b exp 000000", {fault_latched, chan_err, fault_under});
         fails++;
      end
   endtask

   // Sequence and final report
   initial begin
      test_reset();
      test_run_entry();
      test_over();
      test_under();
      test_chan_err();
      test_clear_vs_trip();
      test_stale();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
